// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared arbiter state encoding and default memory timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_TIMEOUT = 15;
    localparam int DATA_W      = 32;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Saturating busy-cycle counter; flags the final allowed cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_timer
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // last_o marks the TIMEOUT-th busy cycle (count starts at 0 on grant)
    assign last_o = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (instruction/data) arbiter for one memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int AW      = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [AW-1:0]     IA,
    output logic [DATA_W-1:0] IRD,
    output logic              IDone,
    input  logic              DReq,
    input  logic              DWE,
    input  logic [AW-1:0]     DA,
    input  logic [DATA_W-1:0] DWD,
    output logic [DATA_W-1:0] DRD,
    output logic              DDone,
    output logic              MemReq,
    output logic              MemWE,
    output logic [AW-1:0]     MemA,
    output logic [DATA_W-1:0] MemWD,
    input  logic [DATA_W-1:0] MemRD,
    input  logic              MemReady,
    output logic              Stall,
    output logic              Error
);

    arb_state_e        state_q, state_d;
    logic              srv_d_q, srv_d_d;
    logic              last_d_q, last_d_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] ird_q, ird_d;
    logic [DATA_W-1:0] drd_q, drd_d;
    logic              err_q, err_d;
    logic              busy_w;
    logic              tmo_last_w;
    logic              gnt_d_w;
    logic              gnt_i_w;

    assign busy_w = (state_q == IBUSY) || (state_q == DBUSY);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .clr_i  (!busy_w),
        .en_i   (busy_w),
        .last_o (tmo_last_w)
    );

    // Contention goes to the port that was not served last
    assign gnt_d_w = DReq && (!IReq || !last_d_q);
    assign gnt_i_w = IReq && !gnt_d_w;

    always_comb begin
        state_d  = state_q;
        srv_d_d  = srv_d_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wd_d     = wd_q;
        ird_d    = ird_q;
        drd_d    = drd_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_d_w) begin
                    srv_d_d = 1'b1;
                    addr_d  = DA;
                    we_d    = DWE;
                    wd_d    = DWD;
                    if (DA[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = DBUSY;
                    end
                end else if (gnt_i_w) begin
                    srv_d_d = 1'b0;
                    addr_d  = IA;
                    we_d    = 1'b0;
                    wd_d    = '0;
                    state_d = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (MemReady) begin
                    if (state_q == IBUSY) begin
                        ird_d = MemRD;
                    end else if (!we_q) begin
                        drd_d = MemRD;
                    end
                    state_d = DONE;
                end else if (tmo_last_w) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d_d = srv_d_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= IDLE;
            srv_d_q  <= 1'b0;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wd_q     <= '0;
            ird_q    <= '0;
            drd_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            srv_d_q  <= srv_d_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
            ird_q    <= ird_d;
            drd_q    <= drd_d;
            err_q    <= err_d;
        end
    end

    assign MemReq = busy_w;
    assign MemWE  = (state_q == DBUSY) && we_q;
    assign MemA   = addr_q;
    assign MemWD  = wd_q;
    assign IRD    = ird_q;
    assign DRD    = drd_q;
    assign IDone  = (state_q == DONE) && !srv_d_q;
    assign DDone  = (state_q == DONE) && srv_d_q;
    assign Error  = err_q;
    assign Stall  = (IReq && !IDone) || (DReq && !DDone);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW  = 32;
    localparam int TMO = DEF_TIMEOUT;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          IReq, DReq, DWE, MemReady;
    logic          IDone, DDone, MemReq, MemWE, Stall, Error;
    logic [AW-1:0] IA, DA, MemA;
    logic [31:0]   IRD, DRD, DWD, MemWD, MemRD;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    bit          m_last_d;
    bit          m_err;
    logic [31:0] m_ird, m_drd;

    mem_arbiter #(.TIMEOUT(TMO), .AW(AW)) dut (
        .CLK(CLK), .Reset(Reset),
        .IReq(IReq), .IA(IA), .IRD(IRD), .IDone(IDone),
        .DReq(DReq), .DWE(DWE), .DA(DA), .DWD(DWD), .DRD(DRD), .DDone(DDone),
        .MemReq(MemReq), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD),
        .MemRD(MemRD), .MemReady(MemReady),
        .Stall(Stall), .Error(Error)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_d = 1'b0;
        m_err    = 1'b0;
        m_ird    = '0;
        m_drd    = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_memreq"}, MemReq, 0);
        chk({tag, "_memwe"}, MemWE, 0);
        chk({tag, "_mema"}, MemA, 0);
        chk({tag, "_memwd"}, MemWD, 0);
        chk({tag, "_done"}, {IDone, DDone}, 0);
        chk({tag, "_ird"}, IRD, 0);
        chk({tag, "_drd"}, DRD, 0);
        chk({tag, "_error"}, Error, 0);
    endtask

    // One grant-to-idle transaction on one port; starts in an IDLE cycle
    task automatic serve(input bit p_d, input int wait_n, input bit tmo,
                         input logic [31:0] rdata, input bit other_pending);
        bit            mis;
        bit            wr;
        int            busy;
        logic [AW-1:0] a;
        mis  = p_d && (DA[1:0] != 2'b00);
        wr   = p_d && DWE;
        a    = p_d ? DA : IA;
        busy = tmo ? TMO : wait_n + 1;
        step();
        if (!mis) begin
            for (int c = 0; c < busy; c++) begin
                chk("busy_memreq", MemReq, 1);
                chk("busy_mema", MemA, a);
                chk("busy_memwe", MemWE, wr);
                if (wr) chk("busy_memwd", MemWD, DWD);
                chk("busy_done", {IDone, DDone}, 0);
                chk("busy_stall", Stall, 1);
                MemReady = !tmo && (c == busy - 1);
                MemRD    = MemReady ? rdata : $urandom;
                step();
            end
            if (tmo)        m_err = 1'b1;
            else if (!p_d)  m_ird = rdata;
            else if (!wr)   m_drd = rdata;
        end else begin
            m_err = 1'b1;
        end
        chk("done_idone", IDone, !p_d);
        chk("done_ddone", DDone, p_d);
        chk("done_memreq", MemReq, 0);
        chk("done_stall", Stall, other_pending);
        chk("done_error", Error, m_err);
        chk("done_ird", IRD, m_ird);
        chk("done_drd", DRD, m_drd);
        m_last_d = p_d;
        if (p_d) DReq = 1'b0; else IReq = 1'b0;
        // Stray MemReady outside a busy window must have no effect
        MemReady = 1'($urandom);
        MemRD    = $urandom;
        step();
        chk("idle_done", {IDone, DDone}, 0);
        chk("idle_memreq", MemReq, 0);
        chk("idle_stall", Stall, other_pending);
        chk("idle_ird", IRD, m_ird);
        chk("idle_drd", DRD, m_drd);
        chk("idle_error", Error, m_err);
    endtask

    task automatic round(input bit ri, input bit rd, input int wi, input int wd_n,
                         input bit tmo, input logic [31:0] rdi, input logic [31:0] rdd);
        bit first_d;
        IReq    = ri;
        DReq    = rd;
        first_d = rd && (!ri || !m_last_d);
        if (ri && rd) begin
            serve(first_d, first_d ? wd_n : wi, tmo, first_d ? rdd : rdi, 1'b1);
            serve(!first_d, first_d ? wi : wd_n, 1'b0, first_d ? rdi : rdd, 1'b0);
        end else begin
            serve(rd, rd ? wd_n : wi, tmo, rd ? rdd : rdi, 1'b0);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        IReq = 0; DReq = 0; DWE = 0; MemReady = 0;
        step();
        chk_quiet("reset");
        chk("reset_stall", Stall, 0);
        Reset = 1'b1;
        model_reset();
        step();
    endtask

    initial begin
        Reset = 1'b0;
        IReq = 0; DReq = 0; DWE = 0; MemReady = 0;
        IA = '0; DA = '0; DWD = '0; MemRD = '0;
        step();
        do_reset();

        // Both requesting from reset: data first, then alternation
        for (int k = 0; k < 4; k++) begin
            IA = $urandom; DA = $urandom & ~32'h3; DWE = 1'b0; DWD = $urandom;
            round(1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                  $urandom, $urandom);
        end

        // Instruction fetch with 3 wait states
        IA = 32'h8;
        round(1'b1, 1'b0, 3, 0, 1'b0, 32'h2002_0005, 32'h0);
        chk("ifetch_ird", IRD, 32'h2002_0005);
        chk("ifetch_stall", Stall, 0);

        // Data write: DRD must be untouched
        DA = 32'h54; DWD = 32'h7; DWE = 1'b1;
        round(1'b0, 1'b1, 0, 1, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // Randomized mixed traffic
        for (int k = 0; k < 30; k++) begin
            int rc;
            rc  = $urandom_range(1, 3);
            IA  = $urandom;
            DA  = ($urandom_range(0, 7) == 0) ? $urandom | 32'h1 : $urandom & ~32'h3;
            DWE = 1'($urandom);
            DWD = $urandom;
            round(rc[0], rc[1], $urandom_range(0, 4), $urandom_range(0, 4), 1'b0,
                  $urandom, $urandom);
        end

        // Misaligned data access from a clean state
        do_reset();
        DA = 32'h51; DWE = 1'b0;
        round(1'b0, 1'b1, 0, 0, 1'b0, 32'h0, 32'h1234_5678);
        chk("misalign_error", Error, 1);

        // Timeout on an instruction fetch
        do_reset();
        IA = 32'h100;
        round(1'b1, 1'b0, 0, 0, 1'b1, 32'h5555_5555, 32'h0);
        chk("tmo_error", Error, 1);
        chk("tmo_ird", IRD, 0);
        step();
        step();
        chk("tmo_error_sticky", Error, 1);

        // Reset asserted in the second busy cycle aborts the access
        DA = 32'h40; DWE = 1'b0; DReq = 1'b1; MemReady = 1'b0;
        step();
        chk("abort_busy1", MemReq, 1);
        step();
        chk("abort_busy2", MemReq, 1);
        Reset = 1'b0;
        step();
        chk_quiet("abort");
        DReq  = 1'b0;
        Reset = 1'b1;
        model_reset();
        step();
        chk("abort_idle_memreq", MemReq, 0);
        chk("abort_idle_done", {IDone, DDone}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
